// File: rtl/execute_muldiv_unit_if.sv
// execute_muldiv_unit_if: execute-stage request/result bundle for the mul/div unit
//   start_E, op_E                    : request strobe and operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   reg_rs_value_E, reg_rt_value_E   : multiplicand/dividend and multiplier/divisor
//   hi_E, lo_E                       : HI/LO result registers
//   busy_E, done_E                   : operation in flight / one-cycle completion pulse
interface execute_muldiv_unit_if;
    logic        start_E;
    logic [1:0]  op_E;
    logic [31:0] reg_rs_value_E;
    logic [31:0] reg_rt_value_E;
    logic [31:0] hi_E;
    logic [31:0] lo_E;
    logic        busy_E;
    logic        done_E;
    modport master (
        output start_E, op_E, reg_rs_value_E, reg_rt_value_E,
        input  hi_E, lo_E, busy_E, done_E
    );
    modport slave (
        input  start_E, op_E, reg_rs_value_E, reg_rt_value_E,
        output hi_E, lo_E, busy_E, done_E
    );
endinterface

// File: rtl/execute_muldiv_unit.sv
// execute_muldiv_unit: 32-cycle iterative multiply/divide with HI/LO result registers
//   clock : rising-edge clock
//   reset : synchronous active-high reset, overrides everything
//   bus   : execute_muldiv_unit_if.slave (start/op/operands in, hi/lo/busy/done out)
module execute_muldiv_unit (
    input  logic                        clock,
    input  logic                        reset,
    execute_muldiv_unit_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state, state_nx;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic [5:0]  count;
    logic [63:0] w, w_nx, mul_nx, div_nx, prod;
    logic [32:0] sum, t, diff;
    logic [31:0] mag_a, mag_b, mag_rs_in, mag_rt_in, quo, rem;
    logic        sgn, sgn_in, busy, done;

    // Magnitudes of the incoming operands seed the work register at acceptance
    assign sgn_in    = ~bus.op_E[0];
    assign mag_rs_in = (sgn_in && bus.reg_rs_value_E[31]) ? -bus.reg_rs_value_E : bus.reg_rs_value_E;
    assign mag_rt_in = (sgn_in && bus.reg_rt_value_E[31]) ? -bus.reg_rt_value_E : bus.reg_rt_value_E;

    assign sgn   = ~op[0];
    assign mag_a = (sgn && a[31]) ? -a : a;
    assign mag_b = (sgn && b[31]) ? -b : b;

    // Multiply: w = {partial upper, remaining multiplier bits}; add then shift right
    assign sum    = {1'b0, w[63:32]} + (w[0] ? {1'b0, mag_a} : 33'd0);
    assign mul_nx = {sum, w[31:1]};
    // Divide: w = {remainder, dividend bits being shifted into quotient}; restoring step
    assign t      = w[63:31];
    assign diff   = t - {1'b0, mag_b};
    assign div_nx = diff[32] ? {t[31:0], w[30:0], 1'b0} : {diff[31:0], w[30:0], 1'b1};
    assign w_nx   = op[1] ? div_nx : mul_nx;

    // Sign correction applied to the value produced by the final iteration
    assign prod = (sgn && (a[31] ^ b[31])) ? -w_nx : w_nx;
    assign quo  = (sgn && (a[31] ^ b[31])) ? -w_nx[31:0] : w_nx[31:0];
    assign rem  = (sgn && a[31]) ? -w_nx[63:32] : w_nx[63:32];

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:    state_nx = bus.start_E ? RUN : IDLE;
            RUN: begin
                busy     = 1'b1;
                state_nx = (count == 6'd1) ? DONE : RUN;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op    <= 2'd0;
            a     <= 32'd0;
            b     <= 32'd0;
            w     <= 64'd0;
            count <= 6'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else if (state == IDLE && bus.start_E) begin
            op    <= bus.op_E;
            a     <= bus.reg_rs_value_E;
            b     <= bus.reg_rt_value_E;
            w     <= {32'd0, bus.op_E[1] ? mag_rs_in : mag_rt_in};
            count <= 6'd32;
        end else if (state == RUN) begin
            w     <= w_nx;
            count <= count - 6'd1;
            if (count == 6'd1) begin
                // Divide by zero reports all-ones quotient and the untouched dividend
                hi <= !op[1] ? prod[63:32] : (b == 32'd0) ? a : rem;
                lo <= !op[1] ? prod[31:0]  : (b == 32'd0) ? 32'hFFFF_FFFF : quo;
            end
        end
    end

    assign bus.hi_E   = hi;
    assign bus.lo_E   = lo;
    assign bus.busy_E = busy;
    assign bus.done_E = done;
endmodule

// File: tb/tb_execute_muldiv_unit.sv
// tb_execute_muldiv_unit: directed vector table plus multi-cycle sequences for execute_muldiv_unit
module tb_execute_muldiv_unit;
    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] prev_hi, prev_lo;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs, rt, hi, lo;
    } vec_t;
    vec_t vecs[13];

    execute_muldiv_unit_if bus();
    execute_muldiv_unit dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [65:0] obs();
        return {bus.busy_E, bus.done_E, bus.hi_E, bus.lo_E};
    endfunction

    // cycle k after acceptance: busy in 1..32, done with new HI/LO in 33, idle after
    function automatic logic [65:0] expect_at(int k, logic [31:0] eh, logic [31:0] el);
        if (k <= 32) return {2'b10, prev_hi, prev_lo};
        if (k == 33) return {2'b01, eh, el};
        return {2'b00, eh, el};
    endfunction

    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] eh, input logic [31:0] el);
        @(negedge clock);
        bus.start_E = 1'b1;
        bus.op_E = op;
        bus.reg_rs_value_E = rs;
        bus.reg_rt_value_E = rt;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clock);
            bus.start_E = 1'b0;
            bus.reg_rs_value_E = ~rs;
            bus.reg_rt_value_E = rt + 32'd1;
            chk($sformatf("%s cyc%0d", name, k), obs(), expect_at(k, eh, el));
        end
        prev_hi = eh;
        prev_lo = el;
    endtask

    initial begin
        int dones;
        int acc[$];
        logic pb;
        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[4]  = '{2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[9]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[10] = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
        vecs[12] = '{2'b10, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};

        reset = 1'b1;
        bus.start_E = 1'b1;
        bus.op_E = 2'b01;
        bus.reg_rs_value_E = 32'd5;
        bus.reg_rt_value_E = 32'd5;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset state", obs(), 66'd0);
        reset = 1'b0;
        bus.start_E = 1'b0;
        prev_hi = 32'd0;
        prev_lo = 32'd0;

        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo);

        // Restart attempts and operand churn during RUN/DONE must not disturb MULTU 3x5
        @(negedge clock);
        bus.start_E = 1'b1;
        bus.op_E = 2'b01;
        bus.reg_rs_value_E = 32'd3;
        bus.reg_rt_value_E = 32'd5;
        dones = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            chk($sformatf("ignore cyc%0d", k), obs(), expect_at(k, 32'd0, 32'd15));
            dones += int'(bus.done_E);
            bus.start_E = (k == 10 || k == 33);
            bus.reg_rs_value_E = (k == 10) ? 32'd9 : 32'(k * 37);
            bus.reg_rt_value_E = (k == 10) ? 32'd9 : 32'(k * 91 + 1);
        end
        chk("ignore one done", dones, 1);
        prev_hi = 32'd0;
        prev_lo = 32'd15;

        do_op("pre-abort", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42);

        // Reset in cycle 16 of a DIVU aborts with zeroed HI/LO and no done pulse
        @(negedge clock);
        bus.start_E = 1'b1;
        bus.op_E = 2'b11;
        bus.reg_rs_value_E = 32'd1000;
        bus.reg_rt_value_E = 32'd3;
        dones = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            bus.start_E = 1'b0;
            if (k <= 16) chk($sformatf("abort cyc%0d", k), obs(), {2'b10, 32'd0, 32'd42});
            else         chk($sformatf("abort cyc%0d", k), obs(), 66'd0);
            dones += int'(bus.done_E);
            reset = (k == 16);
        end
        chk("abort no done", dones, 0);
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        do_op("post-abort", 2'b11, 32'd1000, 32'd3, 32'd1, 32'd333);

        // start held high: acceptances in cycles 0, 34, 68
        @(negedge clock);
        bus.start_E = 1'b1;
        bus.op_E = 2'b01;
        bus.reg_rs_value_E = 32'd2;
        bus.reg_rt_value_E = 32'd3;
        dones = 0;
        pb = 1'b0;
        for (int k = 1; k <= 101; k++) begin
            @(negedge clock);
            if (bus.busy_E && !pb) acc.push_back(k - 1);
            pb = bus.busy_E;
            dones += int'(bus.done_E);
            if (k == 101) bus.start_E = 1'b0;
        end
        chk("b2b accept count", acc.size(), 3);
        chk("b2b accept0", (acc.size() > 0) ? acc[0] : -1, 0);
        chk("b2b accept1", (acc.size() > 1) ? acc[1] : -1, 34);
        chk("b2b accept2", (acc.size() > 2) ? acc[2] : -1, 68);
        chk("b2b done count", dones, 3);
        @(negedge clock);
        chk("b2b final idle", obs(), {2'b00, 32'd0, 32'd6});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
